// File: rtl/lsc_uart_pkg.sv
// Shared types and helpers for the UART capture buffer and its receiver.
package lsc_uart_pkg;

  // Capture/dump sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HDR     = 3'd3,
    ST_DATA    = 3'd4
  } cap_state_t;

  // Parity selection codes.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Bit slots within a UART frame: start, eight data bits, optional parity, stop bit(s).
  localparam logic [3:0] SLOT_START  = 4'd0;
  localparam logic [3:0] SLOT_D0     = 4'd1;
  localparam logic [3:0] SLOT_D7     = 4'd8;
  localparam logic [3:0] SLOT_PARITY = 4'd9;

  // Parity bit that goes on the line for a data byte.
  function automatic logic parity_of(input logic [7:0] d, input int par);
    return (par == PAR_ODD) ? ~(^d) : (^d);
  endfunction

  // Index of the final stop-bit slot of a frame.
  function automatic logic [3:0] last_tx_slot(input int par, input int stop_bits);
    return 4'(8 + ((par != PAR_NONE) ? 1 : 0) + stop_bits);
  endfunction

  // Line level for a given slot of the frame carrying byte d.
  function automatic logic tx_slot_bit(input logic [3:0] slot, input logic [7:0] d, input int par);
    if (slot == SLOT_START) return 1'b0;
    if (slot <= SLOT_D7) return d[3'(slot - SLOT_D0)];
    if (slot == SLOT_PARITY && par != PAR_NONE) return parity_of(d, par);
    return 1'b1;
  endfunction

endpackage

// File: rtl/lsc_uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, parity and stop checks.
module lsc_uart_rx
  import lsc_uart_pkg::*;
#(
  parameter int CLK_DIV = 867,
  parameter int PARITY  = PAR_NONE
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_rxd,
  output logic [7:0] o_dout,
  output logic       o_valid,
  output logic       o_rx_err
);

  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BAUD_MID = BW'(CLK_DIV / 2);
  // Only the first stop bit is examined.
  localparam logic [3:0] STOP_SLOT = (PARITY != PAR_NONE) ? SLOT_PARITY + 4'd1 : SLOT_PARITY;

  typedef enum logic {RX_IDLE = 1'b0, RX_FRAME = 1'b1} rx_state_t;

  rx_state_t      state, state_next;
  logic           sync1, sync2, prev;
  logic [BW-1:0]  baud;
  logic [3:0]     slot;
  logic [7:0]     shift;
  logic           par_bit;
  logic           fall, sample, par_ok;

  assign fall   = prev & ~sync2;
  assign sample = (state == RX_FRAME) && (baud == BAUD_MID);
  assign par_ok = (PARITY == PAR_NONE) || (parity_of(shift, PARITY) == par_bit);

  // Bring the asynchronous line into the clock domain; prev feeds edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= i_rxd;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= RX_IDLE;
    else         state <= state_next;
  end

  // Start on a falling edge; leave on a false start or after the first stop sample.
  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:  if (fall) state_next = RX_FRAME;
      RX_FRAME: if (sample && ((slot == SLOT_START && sync2) || slot == STOP_SLOT))
                  state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  // Bit timing, data shift-in, and result/error pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      baud     <= '0;
      slot     <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      o_dout   <= '0;
      o_valid  <= 1'b0;
      o_rx_err <= 1'b0;
    end else begin
      o_valid  <= 1'b0;
      o_rx_err <= 1'b0;
      if (state == RX_IDLE) begin
        baud <= '0;
        slot <= '0;
      end else begin
        if (baud == BAUD_MAX) begin
          baud <= '0;
          slot <= slot + 4'd1;
        end else begin
          baud <= baud + 1'b1;
        end
        if (sample) begin
          if (slot >= SLOT_D0 && slot <= SLOT_D7) shift <= {sync2, shift[7:1]};
          else if (PARITY != PAR_NONE && slot == SLOT_PARITY) par_bit <= sync2;
          if (slot == STOP_SLOT) begin
            if (sync2 && par_ok) begin
              o_dout  <= shift;
              o_valid <= 1'b1;
            end else begin
              o_rx_err <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/lsc_uart_cap_buf.sv
// Arms on request, captures a frame of bytes into RAM, then dumps header,
// length and data over UART TX. Hosts an independent UART receiver.
// Capture input: i_valid qualifies i_din for one cycle; there is no backpressure,
// bytes presented outside CAPTURE are simply dropped.
module lsc_uart_cap_buf
  import lsc_uart_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter int          CLK_DIV   = 867,
  parameter int          PARITY    = 0,
  parameter int          STOP_BITS = 1,
  parameter int          HDR_EN    = 1,
  parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            i_req,
  input  logic [ADDR_W:0] i_amt,
  input  logic            i_frame_rst,
  input  logic [7:0]      i_din,
  input  logic            i_valid,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_txd,
  input  logic            i_rxd,
  output logic [7:0]      o_dout,
  output logic            o_valid,
  output logic            o_rx_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
  localparam logic [3:0] LAST_SLOT = last_tx_slot(PARITY, STOP_BITS);

  cap_state_t       state, state_next;
  logic [ADDR_W:0]  amt, waddr, len, raddr;
  logic [ADDR_W:0]  waddr_inc, len_cap;
  logic [7:0]       mem [DEPTH];
  logic [7:0]       rdata;
  logic [15:0]      len16;
  logic [1:0]       hdr_idx;
  logic             tx_run, tx_prime;
  logic [BW-1:0]    baud;
  logic [3:0]       slot;
  logic [7:0]       tx_byte, next_byte;
  logic             txd_q, done_q;
  logic             wr_en, cap_exit, bit_end, byte_end, dump_end, tx_load_data;

  assign wr_en     = (state == ST_CAPTURE) && i_valid;
  assign waddr_inc = waddr + 1'b1;
  assign cap_exit  = (state == ST_CAPTURE) && ((wr_en && waddr_inc == amt) || i_frame_rst);
  assign len_cap   = wr_en ? waddr_inc : waddr;
  assign len16     = 16'(len);
  assign bit_end   = tx_run && (baud == BAUD_MAX);
  assign byte_end  = bit_end && (slot == LAST_SLOT);
  // A data byte is taken from the RAM output either at the primed start or at a byte boundary.
  assign tx_load_data = (state == ST_DATA) &&
                        ((!tx_run && tx_prime) || (byte_end && !dump_end));

  assign o_busy = (state != ST_IDLE);
  assign o_done = done_q;
  assign o_txd  = txd_q;

  // Byte that follows the one currently on the line.
  always_comb begin
    next_byte = rdata;
    if (state == ST_HDR) begin
      case (hdr_idx)
        2'd0:    next_byte = len16[7:0];
        2'd1:    next_byte = len16[15:8];
        default: next_byte = rdata;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Sequencer transitions; dump_end marks the cycle the final stop bit finishes.
  always_comb begin
    state_next = state;
    dump_end   = 1'b0;
    case (state)
      ST_IDLE:    if (i_req && i_amt != '0) state_next = ST_ARMED;
      ST_ARMED:   if (i_frame_rst) state_next = ST_CAPTURE;
      ST_CAPTURE: if (cap_exit) begin
                    if (HDR_EN != 0) state_next = ST_HDR;
                    else if (len_cap == '0) begin
                      state_next = ST_IDLE;
                      dump_end   = 1'b1;
                    end else state_next = ST_DATA;
                  end
      ST_HDR:     if (byte_end && hdr_idx == 2'd2) begin
                    if (len != '0) state_next = ST_DATA;
                    else begin
                      state_next = ST_IDLE;
                      dump_end   = 1'b1;
                    end
                  end
      ST_DATA:    if (byte_end && raddr == len) begin
                    state_next = ST_IDLE;
                    dump_end   = 1'b1;
                  end
      default:    state_next = ST_IDLE;
    endcase
  end

  // Request latching (clamped to RAM depth), write pointer and captured length.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      amt    <= '0;
      waddr  <= '0;
      len    <= '0;
      done_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && i_req && i_amt != '0)
        amt <= (i_amt > DEPTH_CNT) ? DEPTH_CNT : i_amt;
      if (state == ST_ARMED && i_frame_rst) waddr <= '0;
      else if (wr_en)                       waddr <= waddr_inc;
      if (cap_exit) len <= len_cap;
      done_q <= dump_end;
    end
  end

  // Read pointer: byte 0 leaves at the header-to-data handoff, later bytes one per load.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                       raddr <= '0;
    else if (state == ST_HDR && state_next == ST_DATA) raddr <= (ADDR_W + 1)'(1);
    else if (state != ST_DATA)                         raddr <= '0;
    else if (tx_load_data)                             raddr <= raddr + 1'b1;
  end

  // Byte RAM with registered read; no reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr[ADDR_W-1:0]] <= i_din;
    rdata <= mem[raddr[ADDR_W-1:0]];
  end

  // UART transmitter. Two prime cycles after capture let the RAM output settle on the
  // byte written in the exit cycle; after that frames run back to back.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_run   <= 1'b0;
      tx_prime <= 1'b0;
      baud     <= '0;
      slot     <= '0;
      tx_byte  <= '0;
      hdr_idx  <= '0;
      txd_q    <= 1'b1;
    end else if (state != ST_HDR && state != ST_DATA) begin
      tx_run   <= 1'b0;
      tx_prime <= 1'b0;
      baud     <= '0;
      slot     <= '0;
      hdr_idx  <= '0;
      txd_q    <= 1'b1;
    end else if (!tx_run) begin
      if (!tx_prime) begin
        tx_prime <= 1'b1;
      end else begin
        tx_run  <= 1'b1;
        tx_byte <= (state == ST_HDR) ? HDR_BYTE : rdata;
        slot    <= SLOT_START;
        baud    <= '0;
        txd_q   <= 1'b0;
      end
    end else if (dump_end) begin
      tx_run <= 1'b0;
      txd_q  <= 1'b1;
    end else if (bit_end) begin
      baud <= '0;
      if (slot == LAST_SLOT) begin
        tx_byte <= next_byte;
        slot    <= SLOT_START;
        txd_q   <= 1'b0;
        if (state == ST_HDR) hdr_idx <= hdr_idx + 2'd1;
      end else begin
        slot  <= slot + 4'd1;
        txd_q <= tx_slot_bit(slot + 4'd1, tx_byte, PARITY);
      end
    end else begin
      baud <= baud + 1'b1;
    end
  end

  lsc_uart_rx #(
    .CLK_DIV (CLK_DIV),
    .PARITY  (PARITY)
  ) u_rx (
    .clk      (clk),
    .resetn   (resetn),
    .i_rxd    (i_rxd),
    .o_dout   (o_dout),
    .o_valid  (o_valid),
    .o_rx_err (o_rx_err)
  );

endmodule

// File: doc/lsc_uart_cap_buf.md
Name: lsc_uart_cap_buf

Overview:
Parametrised single-clock successor to the UART capture buffer. On request it arms, then captures up to a programmable number of bytes from a streaming source at the next frame boundary into an inferred byte RAM. It then dumps a header, a 16-bit length and the captured bytes over UART TX. An independent UART RX returns host bytes with framing/parity error reporting. Sits between the pipeline debug tap and the board UART pins.

Parameters:
ADDR_W, 12, RAM depth = 2**ADDR_W bytes; legal 4..15
CLK_DIV, 867, clk cycles per UART bit; legal >= 8
PARITY, 0, 0 = none, 1 = even, 2 = odd (TX and RX)
STOP_BITS, 1, 1 or 2 (TX); RX checks the first stop bit only
HDR_EN, 1, 1 = prefix dump with HDR_BYTE, len_lo, len_hi
HDR_BYTE, 8'hA5, header marker byte

Ports:
clk  in  1  single clock
resetn  in  1  asynchronous active-low reset
i_req  in  1  arm request pulse
i_amt  in  ADDR_W+1  bytes to capture; sampled with i_req
i_frame_rst  in  1  frame boundary pulse
i_din  in  8  capture data
i_valid  in  1  capture data qualifier
o_busy  out  1  high from arm until last TX stop bit ends
o_done  out  1  one-cycle pulse when dump completes
o_txd  out  1  UART TX, idle high
i_rxd  in  1  UART RX, asynchronous
o_dout  out  8  received byte
o_valid  out  1  one-cycle pulse with o_dout
o_rx_err  out  1  one-cycle pulse on framing or parity error

Behaviour:
- Reset (async, any state): FSM=IDLE, all counters 0, o_txd=1, o_busy=0, o_done=0, o_dout=0, o_valid=0, o_rx_err=0. Reset mid-dump aborts it; nothing resumes.
- FSM: IDLE -> ARMED -> CAPTURE -> HDR -> DATA -> IDLE.
- IDLE: i_req with i_amt != 0 latches amt = min(i_amt, 2**ADDR_W) and goes to ARMED; o_busy=1 next cycle. i_req with i_amt == 0 is ignored. i_req outside IDLE is ignored.
- ARMED: i_frame_rst -> CAPTURE with waddr=0. i_valid in the same cycle is not written.
- CAPTURE: each i_valid writes mem[waddr] and increments waddr.
  - Exit when a write makes waddr == amt, or on i_frame_rst (short frame). Both in one cycle = single exit; that cycle's byte is written.
  - On exit, len = waddr (may be 0).
  - Next state is HDR if HDR_EN, else DATA. With HDR_EN=0 and len=0, go straight to IDLE with o_done.
- HDR: transmit HDR_BYTE, len[7:0], then {(16-ADDR_W-1)'b0, len} [15:8].
- DATA: transmit mem[0..len-1] in order. RAM read is registered (1-cycle latency); the byte is prefetched during the previous byte's stop bit(s) so there are no idle gaps between bytes.
- After the last stop bit: o_done pulses 1 cycle, o_busy drops in the same cycle, FSM returns to IDLE. i_valid and i_frame_rst are ignored during HDR/DATA.
- TX frame: start(0), d0..d7 LSB first, parity if PARITY != 0, STOP_BITS ones. Each bit lasts exactly CLK_DIV cycles. o_txd is registered.
- RX:
  - i_rxd passes a 2-flop synchroniser.
  - A 1->0 edge while idle starts a frame; sampling is at CLK_DIV/2 (integer divide) into each bit.
  - If the start bit samples 1, it is a false start: return to idle with no output.
  - After the first stop sample, o_dout/o_valid update if stop = 1 and parity is good. Otherwise o_rx_err pulses, o_valid stays 0 and o_dout holds.
  - RX is fully independent of the capture FSM.
- Width rules:
  - len and waddr are ADDR_W+1 bits.
  - The bit counter is 4 bits.
  - The baud counter is $clog2(CLK_DIV) bits and wraps at CLK_DIV-1.

Decomposition:
- Shared package lsc_uart_pkg: FSM state enum, parity codes (PAR_NONE, PAR_EVEN, PAR_ODD), UART bit-slot constants.
- Sub-module lsc_uart_rx (synchroniser, baud counter, shift register, error checks), instantiated once.
- TX, RAM and FSM stay in the top level.

Test Plan:
- CLK_DIV=16, HDR_EN=1, i_amt=4, frame_rst, then 4 bytes 11,22,33,44 -> TX decodes A5,04,00,11,22,33,44; o_done 1 pulse; o_busy low after last stop.
- i_amt=8, frame_rst, 3 bytes, frame_rst -> len=3; TX A5,03,00 plus 3 bytes; the 2nd frame_rst is not captured.
- ADDR_W=4, i_amt=20 -> clamped to 16; 16 bytes dumped; len_lo=10.
- PARITY=1: host sends 0x5A with correct parity -> o_valid, o_dout=5A. Same byte with bad parity -> o_rx_err only. Stop bit forced 0 -> o_rx_err. 4-cycle low glitch -> no output.
- resetn asserted during DATA byte 2 -> o_txd=1 and o_busy=0 immediately. A new i_req after release runs a clean dump.
- i_req with i_amt=0 -> stays IDLE. i_req during CAPTURE -> ignored, amt unchanged.
